fft_sink_framer: RTL and testbench

Streaming adapter between the asynchronous sample FIFO read port (MCLK domain) and the FFT core sink. It pops 24-bit audio samples from the FIFO whenever data is available and the downstream path has room. It presents them to the FFT as Avalon-ST packets of exactly FFT_POINTS samples, generating sink_valid/sink_sop/sink_eop and honouring sink_ready backpressure. Framing starts and stops only on frame boundaries, so the FFT never sees a truncated packet.

---
 rtl/fft_sink_framer.sv | 117 +++++++++++
 tb/tb_fft_sink_framer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sink_framer.sv
// Pops samples from the MCLK-domain sample FIFO into a 2-entry skid buffer and
// emits them to the FFT sink as fixed-length Avalon-ST packets.
module fft_sink_framer #(
    parameter int SAMPLE_LENGTH = 24,
    parameter int FFT_POINTS    = 1024
) (
    input  logic                     MCLK,
    input  logic                     RESET,
    input  logic                     enable,
    input  logic [SAMPLE_LENGTH-1:0] fifo_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic                     sink_ready,
    output logic                     sink_valid,
    output logic                     sink_sop,
    output logic                     sink_eop,
    output logic [SAMPLE_LENGTH-1:0] sink_real,
    output logic [SAMPLE_LENGTH-1:0] sink_imag,
    output logic [15:0]              frame_count,
    output logic                     busy
);

    localparam int IDX_W = $clog2(FFT_POINTS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   r_state;
    logic [1:0]               r_occ;
    logic                     r_pending;
    logic                     r_head;
    logic [SAMPLE_LENGTH-1:0] r_buf [2];
    logic [IDX_W-1:0]         r_rd_idx;
    logic [IDX_W-1:0]         r_out_idx;
    logic                     r_frame_rd;
    logic [15:0]              r_frame_count;

    logic w_stop;
    logic w_rd;
    logic w_xfer;
    logic w_valid;

    // Stopping is only allowed once this run has issued reads and rd_idx is back
    // on a frame boundary; the read is suppressed in that same cycle so no sample
    // of a new frame is ever popped.
    assign w_stop  = (r_state == RUN) & ~enable & r_frame_rd & (r_rd_idx == '0);
    assign w_rd    = (r_state == RUN) & ~w_stop & ~fifo_empty &
                     ((r_occ + {1'b0, r_pending}) < 2'd2);
    assign w_valid = (r_occ != 2'd0);
    assign w_xfer  = w_valid & sink_ready;

    assign fifo_rd_en  = w_rd;
    assign sink_valid  = w_valid;
    assign sink_real   = r_buf[r_head];
    assign sink_imag   = '0;
    assign sink_sop    = w_valid & (r_out_idx == '0);
    assign sink_eop    = w_valid & (r_out_idx == IDX_W'(FFT_POINTS - 1));
    assign frame_count = r_frame_count;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            r_occ         <= '0;
            r_pending     <= 1'b0;
            r_head        <= 1'b0;
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
            r_rd_idx      <= '0;
            r_out_idx     <= '0;
            r_frame_rd    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_pending <= w_rd;
            if (w_rd)
                r_rd_idx <= r_rd_idx + IDX_W'(1);

            // Write slot is head+occ; occ<=1 whenever data lands, so bit 0 suffices.
            if (r_pending)
                r_buf[r_head ^ r_occ[0]] <= fifo_data;
            if (w_xfer)
                r_head <= ~r_head;

            case ({r_pending, w_xfer})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            if (w_xfer) begin
                r_out_idx <= r_out_idx + IDX_W'(1);
                if (sink_eop)
                    r_frame_count <= r_frame_count + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    r_frame_rd <= 1'b0;
                    if (enable)
                        r_state <= RUN;
                end
                RUN: begin
                    if (w_rd)
                        r_frame_rd <= 1'b1;
                    if (w_stop)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    r_frame_rd <= 1'b0;
                    if ((r_occ == 2'd0) && !r_pending)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sink_framer.sv
// Self-checking bench for fft_sink_framer: a FIFO model plus a stream-level
// scoreboard (sample order, frame position, stall stability) run every cycle.
module tb_fft_sink_framer;

    localparam int SL = 24;
    localparam int NP = 8;

    logic          MCLK = 1'b0;
    logic          RESET;
    logic          enable;
    logic [SL-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          sink_ready;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic [SL-1:0] sink_real;
    logic [SL-1:0] sink_imag;
    logic [15:0]   frame_count;
    logic          busy;

    always #10 MCLK = ~MCLK;

    fft_sink_framer #(.SAMPLE_LENGTH(SL), .FFT_POINTS(NP)) dut (
        .MCLK(MCLK), .RESET(RESET), .enable(enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .frame_count(frame_count), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [SL-1:0] q_src[$];
    logic [SL-1:0] q_exp[$];
    int            reads = 0;
    int            xfers = 0;
    int            n_valid = 0;
    bit            rd_last = 0;
    logic [SL-1:0] data_next = '0;
    bit            gap = 0, refill = 0, ready_rand = 0, ready_fix = 1, tb_en = 0;
    bit            prev_stall = 0;
    logic [SL-1:0] prev_real = '0;
    logic          prev_sop = 1'b0, prev_eop = 1'b0;

    typedef struct {
        bit            en;
        bit            rd;
        bit            valid;
        logic [SL-1:0] dat;
        bit            sop;
        bit            eop;
        bit            bsy;
        int            fc;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream-level reference: every word read must leave in order, frame
    // position is the transfer count modulo NP, frames completed = transfers/NP.
    task automatic model_check();
        chk("imag_zero", 32'(sink_imag), 32'd0);
        chk("in_flight_le2", 32'((reads - xfers) <= 2), 32'd1);
        chk("frame_count", 32'(frame_count), 32'((xfers / NP) % 65536));
        if (prev_stall) begin
            chk("stall_valid", 32'(sink_valid), 32'd1);
            chk("stall_real", 32'(sink_real), 32'(prev_real));
            chk("stall_sop", 32'(sink_sop), 32'(prev_sop));
            chk("stall_eop", 32'(sink_eop), 32'(prev_eop));
        end
        if (sink_valid) begin
            n_valid++;
            chk("valid_has_data", 32'(q_exp.size() > 0), 32'd1);
            if (q_exp.size() > 0)
                chk("real_order", 32'(sink_real), 32'(q_exp[0]));
            chk("sop_pos", 32'(sink_sop), 32'((xfers % NP) == 0));
            chk("eop_pos", 32'(sink_eop), 32'((xfers % NP) == NP - 1));
            if (sink_ready) begin
                if (q_exp.size() > 0) void'(q_exp.pop_front());
                xfers++;
            end
        end else begin
            chk("sop_idle", 32'(sink_sop), 32'd0);
            chk("eop_idle", 32'(sink_eop), 32'd0);
        end
        if (fifo_rd_en) begin
            chk("rd_not_empty", 32'(fifo_empty), 32'd0);
            if (q_src.size() > 0) begin
                data_next = q_src.pop_front();
                q_exp.push_back(data_next);
            end
            reads++;
        end
        rd_last    = fifo_rd_en;
        prev_stall = sink_valid && !sink_ready;
        prev_real  = sink_real;
        prev_sop   = sink_sop;
        prev_eop   = sink_eop;
    endtask

    task automatic cycle();
        @(negedge MCLK);
        enable     = tb_en;
        sink_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        fifo_data  = rd_last ? data_next : SL'($urandom);
        if (refill)
            while (q_src.size() < 4) q_src.push_back(SL'($urandom));
        fifo_empty = gap || (q_src.size() == 0);
        #1;
        model_check();
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge MCLK);
        RESET = 1'b0;
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(sink_valid), 32'd0);
        chk("rst_sop", 32'(sink_sop), 32'd0);
        chk("rst_eop", 32'(sink_eop), 32'd0);
        chk("rst_real", 32'(sink_real), 32'd0);
        chk("rst_imag", 32'(sink_imag), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        q_exp.delete();
        reads      = 0;
        xfers      = 0;
        rd_last    = 0;
        prev_stall = 0;
        repeat (ncyc) @(negedge MCLK);
        RESET = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) cycle();
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0;

        RESET      = 1'b0;
        enable     = 1'b0;
        sink_ready = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // FFT_POINTS=8 single-frame timeline, FIFO preloaded, sink_ready=1.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 1, 2, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 1, 3, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 4, 0, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 5, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 1, 6, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 7, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 1, 8, 0, 1, 1, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1};

        for (int v = 1; v <= 16; v++) q_src.push_back(SL'(v));

        // Reset then idle with data available
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(sink_valid), 32'd0);
            chk("idle_real", 32'(sink_real), 32'd0);
        end

        // Single frame from a one-cycle enable pulse
        for (int i = 0; i < 16; i++) begin
            tb_en = tbl[i].en;
            cycle();
            chk($sformatf("tbl%0d_rd", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_valid", i), 32'(sink_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_fc", i), 32'(frame_count), 32'(tbl[i].fc));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_real", i), 32'(sink_real), 32'(tbl[i].dat));
                chk($sformatf("tbl%0d_sop", i), 32'(sink_sop), 32'(tbl[i].sop));
                chk($sformatf("tbl%0d_eop", i), 32'(sink_eop), 32'(tbl[i].eop));
            end
        end
        for (int i = 0; i < 5; i++) cycle();
        chk("single_reads", 32'(reads), 32'd8);
        chk("single_left", 32'(q_src.size()), 32'd8);

        // Random backpressure with a continuously refilled FIFO
        refill     = 1;
        ready_rand = 1;
        tb_en      = 1;
        repeat (300) cycle();
        tb_en = 0;
        wait_idle("bp_idle");
        chk("bp_reads_eq_xfers", 32'(reads), 32'(xfers));
        chk("bp_frame_boundary", 32'(xfers % NP), 32'd0);
        chk("bp_buffer_empty", 32'(q_exp.size()), 32'd0);

        // Underrun: FIFO empty for 20 cycles after 3 reads of a frame
        ready_rand = 0;
        ready_fix  = 1;
        r0         = reads;
        tb_en      = 1;
        for (int i = 0; i < 50 && reads < r0 + 3; i++) cycle();
        chk("ur_three_reads", 32'(reads), 32'(r0 + 3));
        gap   = 1;
        tb_en = 0;
        repeat (4) cycle();
        n_valid = 0;
        repeat (16) cycle();
        chk("ur_gap_no_valid", 32'(n_valid), 32'd0);
        chk("ur_pos_in_frame", 32'(xfers % NP), 32'd3);
        gap = 0;
        wait_idle("ur_idle");
        chk("ur_frame_done", 32'(xfers % NP), 32'd0);

        // Stop request after 5 reads of frame 2
        do_reset(1);
        tb_en = 1;
        for (int i = 0; i < 200 && reads < NP + 5; i++) cycle();
        chk("stop_reads13", 32'(reads), 32'(NP + 5));
        tb_en = 0;
        wait_idle("stop_idle");
        chk("stop_reads16", 32'(reads), 32'(2 * NP));
        chk("stop_fc2", 32'(frame_count), 32'd2);
        chk("stop_xfers16", 32'(xfers), 32'(2 * NP));

        // Reset with out_idx=4, then a clean restart
        tb_en = 1;
        for (int i = 0; i < 200 && xfers < 2 * NP + 4; i++) cycle();
        chk("mid_pos4", 32'(xfers), 32'(2 * NP + 4));
        do_reset(2);
        for (int i = 0; i < 50 && !sink_valid; i++) cycle();
        chk("mid_restart_valid", 32'(sink_valid), 32'd1);
        chk("mid_restart_sop", 32'(sink_sop), 32'd1);
        tb_en = 0;
        for (int i = 0; i < 200 && xfers < NP; i++) cycle();
        chk("mid_eight_xfers", 32'(xfers), 32'(NP));
        wait_idle("mid_idle");
        chk("mid_fc1", 32'(frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
